// File: rtl/mem_pkg.sv
// Shared widths, FSM state encoding and latched-request record for the MEM-stage load/store unit.
package mem_pkg;

  localparam int ADDR_W = 16;
  localparam int DATA_W = 16;
  localparam int BYTE_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HI   = 2'd1,
    LO   = 2'd2,
    DONE = 2'd3
  } lsu_state_t;

  typedef struct packed {
    logic              write;
    logic              byte_acc;
    logic              sgn;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } mem_req_t;

endpackage

// File: rtl/mem_access_unit.sv
// Serialises one word/byte load or store into big-endian byte-port cycles; word latency 3, byte 2, misaligned 1.
// Accepts a request only in IDLE (o_req_ready); o_busy stalls the pipeline for the whole access.
module mem_access_unit
  import mem_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_req_valid,
  output logic              o_req_ready,
  input  logic              i_req_write,
  input  logic              i_req_byte,
  input  logic              i_req_signed,
  input  logic [ADDR_W-1:0] i_req_addr,
  input  logic [DATA_W-1:0] i_req_wdata,
  output logic              o_busy,
  output logic              o_rsp_valid,
  output logic [DATA_W-1:0] o_rsp_rdata,
  output logic              o_rsp_err,
  output logic              o_mem_we,
  output logic              o_mem_re,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [BYTE_W-1:0] o_mem_wdata,
  input  logic [BYTE_W-1:0] i_mem_rdata
);

  lsu_state_t        state, state_nxt;
  mem_req_t          req;
  logic [DATA_W-1:0] result;
  logic              err;
  logic              misaligned;

  assign misaligned = ~i_req_byte & i_req_addr[0];

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state  <= IDLE;
      req    <= '0;
      result <= '0;
      err    <= 1'b0;
    end else begin
      state <= state_nxt;
      unique case (state)
        IDLE: begin
          if (i_req_valid) begin
            req.write    <= i_req_write;
            req.byte_acc <= i_req_byte;
            req.sgn      <= i_req_signed;
            req.addr     <= i_req_addr;
            req.wdata    <= i_req_wdata;
            // Cleared here so stores and errors report zero read data.
            result       <= '0;
            err          <= misaligned;
          end
        end
        HI: begin
          if (!req.write) result[15:8] <= i_mem_rdata;
        end
        LO: begin
          if (!req.write) begin
            if (req.byte_acc) result <= {{BYTE_W{req.sgn & i_mem_rdata[7]}}, i_mem_rdata};
            else              result[7:0] <= i_mem_rdata;
          end
        end
        DONE: ;
      endcase
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (i_req_valid) begin
          if (misaligned)      state_nxt = DONE;
          else if (i_req_byte) state_nxt = LO;
          else                 state_nxt = HI;
        end
      end
      HI:   state_nxt = LO;
      LO:   state_nxt = DONE;
      DONE: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    o_req_ready = (state == IDLE);
    o_busy      = (state != IDLE);
    o_rsp_valid = (state == DONE);
    o_rsp_rdata = '0;
    o_rsp_err   = 1'b0;
    o_mem_we    = 1'b0;
    o_mem_re    = 1'b0;
    o_mem_addr  = '0;
    o_mem_wdata = '0;
    unique case (state)
      IDLE: ;
      HI: begin
        o_mem_we    = req.write;
        o_mem_re    = ~req.write;
        o_mem_addr  = req.addr;
        o_mem_wdata = req.wdata[15:8];
      end
      LO: begin
        o_mem_we    = req.write;
        o_mem_re    = ~req.write;
        // Aligned words have addr[0]=0, so the +1 never wraps.
        o_mem_addr  = req.byte_acc ? req.addr : req.addr + ADDR_W'(1);
        o_mem_wdata = req.wdata[7:0];
      end
      DONE: begin
        o_rsp_rdata = result;
        o_rsp_err   = err;
      end
    endcase
  end

endmodule
